// File: rtl/gpcfg_pkg.sv
// Shared GPCFG definitions: MDMC mode encodings, command word / completion record layout,
// completion tracker states and status register bit positions.
package gpcfg_pkg;

  typedef enum logic [3:0] {
    ModeNtt  = 4'd1,
    ModeIntt = 4'd2,
    ModeMul  = 4'd3,
    ModeAdd  = 4'd4,
    ModeSub  = 4'd5,
    ModeCmul = 4'd6,
    ModeDma  = 4'd7,
    ModeSqr  = 4'd8,
    ModeNmul = 4'd9
  } mode_e;

  localparam int unsigned CmdModeMsb = 27;
  localparam int unsigned CmdModeLsb = 24;
  localparam int unsigned CmdAddrMsb = 23;
  localparam int unsigned CmdAddrLsb = 16;

  typedef struct packed {
    logic [3:0]  seq;
    logic [3:0]  mode;
    logic [7:0]  addr;
    logic [15:0] cycles;
  } compl_rec_t;

  typedef enum logic {
    StIdle,
    StBusy
  } trk_state_e;

  localparam int unsigned StatEmpty    = 0;
  localparam int unsigned StatFull     = 1;
  localparam int unsigned StatOvf      = 2;
  localparam int unsigned StatErr      = 3;
  localparam int unsigned StatCountLsb = 8;

  function automatic logic [15:0] sat_inc(logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/gp_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; a push into a full FIFO is dropped and flagged
// unless a pop in the same cycle frees the slot.
module gp_sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       hclk,
  input  logic                       hreset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       drop
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count   = wptr_q - rptr_q;
  assign head    = mem_q[rptr_q[AW-1:0]];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge hclk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/completion_fifo.sv
// Tracks the in-flight MDMC command, times it and queues completion records for host pops.
// Define COMPL_FIFO_IRQ_EN to build the registered occupancy/error interrupt.
module completion_fifo
  import gpcfg_pkg::*;
#(
  parameter logic [15:0] CFG_ADDR   = 16'h0,
  parameter logic [15:0] STAT_ADDR  = 16'h4,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned IRQ_THRESH = 1
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byte_en,
  input  logic        rd_en,
  input  logic [31:0] rd_addr,
  output logic [31:0] rdata,
  input  logic        cmd_start,
  input  logic [31:0] cmd_word,
  input  logic        mdmc_done,
  output logic        busy,
  output logic        irq
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  trk_state_e  state_q, state_d;
  logic [3:0]  mode_q, mode_d, seq_q, seq_d;
  logic [7:0]  addr_q, addr_d;
  logic [15:0] cnt_q, cnt_d;
  logic        ovf_q, ovf_d, err_q, err_d;
  logic        latch, complete, err_set, pop_req, stat_wr;
  compl_rec_t  rec;
  logic [31:0] fifo_head, status;
  logic        fifo_full, fifo_empty, fifo_drop;
  logic [CW-1:0] fifo_count;

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (cmd_start) state_d = StBusy;
      StBusy: if (mdmc_done && !cmd_start) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy     = (state_q == StBusy);
    complete = busy && mdmc_done;
    // A start only relatches when the tracker is free or the old command finishes this cycle.
    latch    = cmd_start && (!busy || mdmc_done);
    err_set  = (!busy && mdmc_done) || (busy && cmd_start && !mdmc_done);
  end

  assign pop_req = rd_en && (rd_addr[15:0] == CFG_ADDR);
  assign stat_wr = wr_en && (wr_addr[15:0] == STAT_ADDR) && byte_en[0];

  always_comb begin
    mode_d = mode_q;
    addr_d = addr_q;
    cnt_d  = cnt_q;
    seq_d  = complete ? seq_q + 4'd1 : seq_q;
    if (latch) begin
      mode_d = cmd_word[CmdModeMsb:CmdModeLsb];
      addr_d = cmd_word[CmdAddrMsb:CmdAddrLsb];
      cnt_d  = '0;
    end else if (busy) begin
      cnt_d  = sat_inc(cnt_q);
    end
    // Set events win over a simultaneous host clear.
    ovf_d = fifo_drop | (ovf_q & ~(stat_wr & wdata[StatOvf]));
    err_d = err_set   | (err_q & ~(stat_wr & wdata[StatErr]));
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      mode_q <= '0;
      addr_q <= '0;
      cnt_q  <= '0;
      seq_q  <= '0;
      ovf_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
      seq_q  <= seq_d;
      ovf_q  <= ovf_d;
      err_q  <= err_d;
    end
  end

  // Counter holds k-1 when done arrives k edges after start.
  assign rec = '{seq: seq_q, mode: mode_q, addr: addr_q, cycles: sat_inc(cnt_q)};

  gp_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .hclk      (hclk),
    .hreset    (hreset),
    .push      (complete),
    .push_data (rec),
    .pop       (pop_req),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .drop      (fifo_drop)
  );

  always_comb begin
    status                       = '0;
    status[StatEmpty]            = fifo_empty;
    status[StatFull]             = fifo_full;
    status[StatOvf]              = ovf_q;
    status[StatErr]              = err_q;
    status[StatCountLsb +: 5]    = 5'(fifo_count);
  end

  always_comb begin
    rdata = '0;
    if (pop_req)                                   rdata = fifo_empty ? '0 : fifo_head;
    else if (rd_en && rd_addr[15:0] == STAT_ADDR)  rdata = status;
  end

`ifdef COMPL_FIFO_IRQ_EN
  logic irq_q;
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) irq_q <= 1'b0;
    else        irq_q <= (32'(fifo_count) >= IRQ_THRESH) | ovf_q | err_q;
  end
  assign irq = irq_q;
`else
  logic unused_thresh;
  assign unused_thresh = ^IRQ_THRESH;
  assign irq = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{wr_addr[31:16], rd_addr[31:16], wdata[31:4], wdata[1:0],
                         byte_en[3:1], cmd_word[31:28], cmd_word[15:0]};

endmodule
